// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - stream MAC-style accumulator of multiplier products with sticky overflow
module product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W:0]     sum;
    logic               beat;

    // One extra bit on the adder captures the carry out of the accumulator
    always_comb begin
        sum  = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
        beat = in_valid && (state_q == ACCUM);
    end

    // Next-state and datapath update; abort overrides everything, including a same-cycle beat
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (abort) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        cnt_d   = len;
                        state_d = (len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc_d = sum[ACC_W-1:0];
                        ovf_d = ovf_q | sum[ACC_W];
                        cnt_d = cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs decoded purely from registered state
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        out_acc   = acc_q;
        out_ovf   = ovf_q;
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - randomized self-checking bench for product_accumulator
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  len = '0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_prod = '0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, out_ovf_a, busy_a;
    logic [15:0] out_acc_a;
    logic        in_ready_b, out_valid_b, out_ovf_b, busy_b;
    logic [9:0]  out_acc_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    product_accumulator u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_prod(in_prod),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a),
        .out_ovf(out_ovf_a), .busy(busy_a)
    );

    product_accumulator #(.ACC_W(10)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_prod(in_prod),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b),
        .out_ovf(out_ovf_b), .busy(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic busy_e, input logic ir_e, input logic ov_e);
        check_eq({tag, "_busy_a"}, busy_a, busy_e);
        check_eq({tag, "_busy_b"}, busy_b, busy_e);
        check_eq({tag, "_in_ready_a"}, in_ready_a, ir_e);
        check_eq({tag, "_in_ready_b"}, in_ready_b, ir_e);
        check_eq({tag, "_out_valid_a"}, out_valid_a, ov_e);
        check_eq({tag, "_out_valid_b"}, out_valid_b, ov_e);
    endtask

    task automatic check_result(input string tag, input int total);
        check_eq({tag, "_acc16"}, out_acc_a, total % 65536);
        check_eq({tag, "_ovf16"}, out_ovf_a, (total >= 65536) ? 1 : 0);
        check_eq({tag, "_acc10"}, out_acc_b, total % 1024);
        check_eq({tag, "_ovf10"}, out_ovf_b, (total >= 1024) ? 1 : 0);
    endtask

    // One complete run: start, n beats with idle gaps, result held for hold cycles, handshake
    task automatic do_run(input int n, input int beats[16], input int gap_lo, input int gap_hi,
                          input int hold);
        int total;
        total = 0;
        for (int i = 0; i < n; i++) total += beats[i];
        start = 1'b1;
        len   = 4'(n);
        step();
        start = 1'b0;
        if (n == 0) begin
            check_flags("len0", 1'b1, 1'b0, 1'b1);
        end else begin
            check_flags("started", 1'b1, 1'b1, 1'b0);
            for (int i = 0; i < n; i++) begin
                int g;
                g = $urandom_range(gap_hi, gap_lo);
                for (int k = 0; k < g; k++) begin
                    in_valid = 1'b0;
                    in_prod  = 8'($urandom);
                    step();
                    check_flags("gap", 1'b1, 1'b1, 1'b0);
                end
                in_valid = 1'b1;
                in_prod  = 8'(beats[i]);
                step();
                in_valid = 1'b0;
                if (i < n - 1) check_flags("beat", 1'b1, 1'b1, 1'b0);
                else           check_flags("last", 1'b1, 1'b0, 1'b1);
            end
        end
        check_result("done", total);
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            start     = 1'($urandom_range(1, 0));
            len       = 4'($urandom);
            step();
            start = 1'b0;
            check_flags("hold", 1'b1, 1'b0, 1'b1);
            check_result("hold", total);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 4'd3;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        check_flags("handshake", 1'b0, 1'b0, 1'b0);
        check_result("after", total);
    endtask

    int beats[16];

    initial begin
        rst_n = 1'b0;
        step();
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        check_result("reset", 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 16; i++) beats[i] = 225;
        do_run(4, beats, 0, 0, 0);
        do_run(5, beats, 0, 0, 1);
        do_run(0, beats, 0, 0, 2);

        beats[0] = 10; beats[1] = 20; beats[2] = 30;
        do_run(3, beats, 2, 2, 5);

        // abort after three beats with a fourth beat presented in the same cycle
        start = 1'b1; len = 4'd6;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_prod = 8'd200;
            step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0; in_valid = 1'b0;
        check_flags("abort", 1'b0, 1'b0, 1'b0);
        check_result("abort", 0);
        beats[0] = 1; beats[1] = 2;
        do_run(2, beats, 0, 0, 0);

        // abort together with start in IDLE
        start = 1'b1; abort = 1'b1; len = 4'd2;
        step();
        start = 1'b0; abort = 1'b0;
        check_flags("abort_start", 1'b0, 1'b0, 1'b0);

        // asynchronous reset in the middle of an accumulation
        start = 1'b1; len = 4'd5;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_prod = 8'd99;
        step();
        step();
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_flags("async_rst", 1'b0, 1'b0, 1'b0);
        check_result("async_rst", 0);
        step();
        rst_n = 1'b1;
        step();
        beats[0] = 255;
        do_run(1, beats, 0, 0, 0);

        // randomized runs against the arithmetic model
        for (int r = 0; r < 25; r++) begin
            int n;
            n = $urandom_range(15, 0);
            for (int i = 0; i < 16; i++) beats[i] = $urandom_range(255, 0);
            do_run(n, beats, 0, $urandom_range(2, 0), $urandom_range(3, 0));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
